// File: rtl/reg_scoreboard_if.sv
// rtl/reg_scoreboard_if.sv - issue/writeback/query bundle for the register scoreboard
interface reg_scoreboard_if #(
    parameter int NUM_REGS = 32
);
    localparam int IDX_W = $clog2(NUM_REGS);
    localparam int CNT_W = $clog2(NUM_REGS + 1);

    logic             i_set_vld;
    logic [IDX_W-1:0] i_set_idx;
    logic             i_clr_vld;
    logic [IDX_W-1:0] i_clr_idx;
    logic [IDX_W-1:0] i_rs1_idx;
    logic [IDX_W-1:0] i_rs2_idx;
    logic                o_rs1_busy;
    logic                o_rs2_busy;
    logic                o_stall;
    logic [NUM_REGS-1:0] o_busy_vec;
    logic [CNT_W-1:0]    o_busy_cnt;
    logic                o_all_idle;
    logic                o_err;

    modport master (
        output i_set_vld, i_set_idx, i_clr_vld, i_clr_idx, i_rs1_idx, i_rs2_idx,
        input  o_rs1_busy, o_rs2_busy, o_stall, o_busy_vec, o_busy_cnt, o_all_idle, o_err
    );

    modport slave (
        input  i_set_vld, i_set_idx, i_clr_vld, i_clr_idx, i_rs1_idx, i_rs2_idx,
        output o_rs1_busy, o_rs2_busy, o_stall, o_busy_vec, o_busy_cnt, o_all_idle, o_err
    );
endinterface

// File: rtl/reg_scoreboard.sv
// rtl/reg_scoreboard.sv - busy-bit register scoreboard with writeback bypass and sticky error
module reg_scoreboard #(
    parameter int NUM_REGS       = 32,
    parameter int ZERO_HARDWIRED = 1
) (
    input logic           i_clk,
    input logic           i_rst,
    reg_scoreboard_if.slave sb
);
    localparam int IDX_W = $clog2(NUM_REGS);
    localparam int CNT_W = $clog2(NUM_REGS + 1);

    logic [NUM_REGS-1:0] busy_q;
    logic [NUM_REGS-1:0] busy_nxt;
    logic [NUM_REGS-1:0] set_hit;
    logic [NUM_REGS-1:0] clr_hit;
    logic [CNT_W-1:0]    cnt_q;
    logic [CNT_W-1:0]    cnt_nxt;
    logic                err_q;
    logic                err_nxt;
    logic                set_oor;
    logic                clr_oor;

    // Busy lookup that reads as idle for indices beyond the table.
    function automatic logic busy_at(input logic [NUM_REGS-1:0] vec, input logic [IDX_W-1:0] idx);
        if (int'(idx) < NUM_REGS) begin
            return vec[idx];
        end
        return 1'b0;
    endfunction

    // Decode set/clear indices to per-entry enables and work out next bitmap, count and error.
    always_comb begin
        set_hit  = '0;
        clr_hit  = '0;
        busy_nxt = '0;
        cnt_nxt  = '0;
        err_nxt  = err_q;
        set_oor  = sb.i_set_vld && (int'(sb.i_set_idx) >= NUM_REGS);
        clr_oor  = sb.i_clr_vld && (int'(sb.i_clr_idx) >= NUM_REGS);
        for (int n = 0; n < NUM_REGS; n++) begin
            if (sb.i_set_vld && (sb.i_set_idx == IDX_W'(n))) begin
                set_hit[n] = 1'b1;
            end
            if (sb.i_clr_vld && (sb.i_clr_idx == IDX_W'(n))) begin
                clr_hit[n] = 1'b1;
            end
        end
        // Register 0 reads as constant zero, so its set/clear are silently dropped.
        if (ZERO_HARDWIRED != 0) begin
            set_hit[0] = 1'b0;
            clr_hit[0] = 1'b0;
        end
        // Releasing an idle entry is a protocol error unless the same entry is being re-issued.
        if (set_oor || clr_oor || (|(clr_hit & ~busy_q & ~set_hit))) begin
            err_nxt = 1'b1;
        end
        busy_nxt = set_hit | (busy_q & ~clr_hit);
        for (int n = 0; n < NUM_REGS; n++) begin
            cnt_nxt = cnt_nxt + CNT_W'(busy_nxt[n]);
        end
    end

    // State update: bitmap, its population count and the sticky error flag move together.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            busy_q <= '0;
            cnt_q  <= '0;
            err_q  <= 1'b0;
        end else begin
            busy_q <= busy_nxt;
            cnt_q  <= cnt_nxt;
            err_q  <= err_nxt;
        end
    end

    // Source queries see the registered bitmap, with an in-flight writeback releasing its target early.
    always_comb begin
        sb.o_rs1_busy = busy_at(busy_q, sb.i_rs1_idx)
                        & ~(sb.i_clr_vld && (sb.i_clr_idx == sb.i_rs1_idx));
        sb.o_rs2_busy = busy_at(busy_q, sb.i_rs2_idx)
                        & ~(sb.i_clr_vld && (sb.i_clr_idx == sb.i_rs2_idx));
        sb.o_stall    = sb.o_rs1_busy | sb.o_rs2_busy;
        sb.o_busy_vec = busy_q;
        sb.o_busy_cnt = cnt_q;
        sb.o_all_idle = (cnt_q == '0);
        sb.o_err      = err_q;
    end
endmodule
